// File: rtl/alu_div_seq.sv
// Sequential restoring divider (DIV/DIVU/REM/REMU) that borrows a shared ALU adder.
// Define ALU_DIV_EARLY_OUT_EN to finish a divide-by-zero straight from PREP.
module alu_div_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   div_op,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W+1:0] alu_lhs,
  output logic [W+1:0] alu_rhs,
  output logic         alu_inv_rhs,
  output logic         alu_op_ctrl,
  output logic [2:0]   alu_arth_out_sel,
  input  logic [W+1:0] alu_adder_result
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StIter = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    dividend_q, dividend_d;
  logic [W-1:0]    divisor_q, divisor_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_quot_q, sign_quot_d;
  logic            sign_rem_q, sign_rem_d;

  logic            is_signed;
  logic            is_rem;
  logic [W:0]      partial;
  logic [W-1:0]    fix_val;
  logic            fix_neg;
  logic            unused_adder_msb;

  // op[0] set means unsigned, op[1] set means remainder.
  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign partial   = {rem_q, dividend_q[W-1]};

  assign unused_adder_msb = alu_adder_result[W];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    sign_quot_d = sign_quot_q;
    sign_rem_d  = sign_rem_q;
    alu_lhs     = '0;
    alu_rhs     = '0;
    alu_inv_rhs = 1'b0;
    fix_val     = is_rem ? rem_q : quot_q;
    fix_neg     = is_rem ? sign_rem_q : (sign_quot_q && (divisor_q != '0));

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StPrep;
          op_d       = div_op;
          dividend_d = in_dividend;
          divisor_d  = in_divisor;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end

      StPrep: begin
        rem_d  = '0;
        quot_d = '0;
        cnt_d  = '0;
        if (is_signed) begin
          dividend_d  = dividend_q[W-1] ? -dividend_q : dividend_q;
          divisor_d   = divisor_q[W-1] ? -divisor_q : divisor_q;
          sign_quot_d = dividend_q[W-1] ^ divisor_q[W-1];
          sign_rem_d  = dividend_q[W-1];
        end else begin
          sign_quot_d = 1'b0;
          sign_rem_d  = 1'b0;
        end
        state_d = StIter;
`ifdef ALU_DIV_EARLY_OUT_EN
        // Operands are still raw here, so the remainder keeps the dividend's sign.
        if (divisor_q == '0) begin
          state_d  = StDone;
          result_d = is_rem ? dividend_q : '1;
        end
`endif
      end

      StIter: begin
        alu_lhs     = {1'b0, partial};
        alu_rhs     = {2'b00, divisor_q};
        alu_inv_rhs = 1'b1;
        // A clear sign bit means the partial remainder covers the divisor.
        if (!alu_adder_result[W+1]) begin
          rem_d  = alu_adder_result[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b1};
        end else begin
          rem_d  = partial[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b0};
        end
        dividend_d = {dividend_q[W-2:0], 1'b0};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        alu_lhs     = '0;
        alu_rhs     = {2'b00, fix_val};
        alu_inv_rhs = 1'b1;
        result_d    = fix_neg ? alu_adder_result[W-1:0] : fix_val;
        state_d     = StDone;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      sign_quot_q <= sign_quot_d;
      sign_rem_q  <= sign_rem_d;
    end
  end

  assign busy             = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
  assign done             = (state_q == StDone);
  assign result           = result_q;
  assign alu_op_ctrl      = 1'b0;
  assign alu_arth_out_sel = 3'b000;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: stimulus pushes expected results, a done monitor pops them.
// The external ALU adder is modelled here as lhs + rhs, or lhs - rhs when inversion is requested.
module tb_alu_div_seq;

  localparam int unsigned W = 32;
  localparam int Lat = 35;
`ifdef ALU_DIV_EARLY_OUT_EN
  localparam int DzLat = 2;
`else
  localparam int DzLat = 35;
`endif

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   div_op;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W+1:0] alu_lhs;
  logic [W+1:0] alu_rhs;
  logic         alu_inv_rhs;
  logic         alu_op_ctrl;
  logic [2:0]   alu_arth_out_sel;
  logic [W+1:0] alu_adder_result;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   errors;
  int   checks;

  alu_div_seq #(.W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .div_op           (div_op),
    .in_dividend      (in_dividend),
    .in_divisor       (in_divisor),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .alu_lhs          (alu_lhs),
    .alu_rhs          (alu_rhs),
    .alu_inv_rhs      (alu_inv_rhs),
    .alu_op_ctrl      (alu_op_ctrl),
    .alu_arth_out_sel (alu_arth_out_sel),
    .alu_adder_result (alu_adder_result)
  );

  assign alu_adder_result = alu_inv_rhs ? (alu_lhs + ~alu_rhs + 1'b1) : (alu_lhs + alu_rhs);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result 0x%0h, expected no done (cycle %0d)", result,
                 cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input bit track);
    start       = 1'b1;
    div_op      = op;
    in_dividend = a;
    in_divisor  = b;
    if (track) sb_q.push_back('{exp, cyc + lat});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
      sb_q.delete();
    end
    step();
  endtask

  task automatic run_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat);
    issue(op, a, b, exp, lat, 1'b1);
    step();
    drain();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    div_op      = '0;
    in_dividend = '0;
    in_divisor  = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", {32'd0, result}, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // DIVU 100/7 with busy tracked cycle by cycle.
    issue(OpDivu, 32'd100, 32'd7, 32'd14, Lat, 1'b1);
    for (int r = 0; r <= 36; r++) begin
      @(negedge clk);
      check($sformatf("busy_rel%0d", r), 64'(busy), 64'((r >= 1 && r <= 34) ? 1 : 0));
      step();
    end
    drain();

    run_one(OpDiv,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, Lat);
    run_one(OpRem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, Lat);
    run_one(OpRemu, 32'hFFFF_FFF9, 32'd2, 32'd1, Lat);
    run_one(OpDivu, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, Lat);
    run_one(OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, Lat);
    run_one(OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, Lat);
    run_one(OpDiv,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, Lat);
    run_one(OpRem,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, Lat);
    run_one(OpDiv,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, Lat);
    run_one(OpRem,  32'd100, 32'hFFFF_FFF9, 32'd2, Lat);
    run_one(OpDivu, 32'd7, 32'd100, 32'd0, Lat);
    run_one(OpRemu, 32'd7, 32'd100, 32'd7, Lat);
    run_one(OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, Lat);

    // Divide by zero.
    run_one(OpDiv,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, DzLat);
    run_one(OpRem,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, DzLat);
    run_one(OpRemu, 32'd5, 32'd0, 32'd5, DzLat);
    run_one(OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, DzLat);

    // Start while busy must be ignored.
    issue(OpDivu, 32'd100, 32'd7, 32'd14, Lat, 1'b1);
    step();
    repeat (9) step();
    issue(OpDivu, 32'd1000, 32'd3, 32'd333, Lat, 1'b0);
    step();
    drain();

    // Reset mid-operation: no done, result cleared.
    issue(OpDivu, 32'd100, 32'd7, 32'd14, Lat, 1'b0);
    step();
    repeat (11) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_result", {32'd0, result}, 64'(0));
    repeat (40) step();

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(OpDivu, 32'd9, 32'd3, 32'd3, Lat, 1'b1);
    step();
    repeat (34) step();
    issue(OpDivu, 32'd8, 32'd2, 32'd4, Lat, 1'b1);
    step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
